// File: rtl/lfsr_rand_range.sv
// Pseudo-random roll source: free-running Galois LFSR with a req/valid front end
// that returns a uniform value in [0, range-1] by rejection sampling.
module lfsr_rand_range #(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED_INIT = '1,
  parameter int                OUT_W     = 3,
  parameter int                MAX_TRIES = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              seed_ld,
  input  logic [LFSR_W-1:0] seed,
  input  logic              req,
  input  logic [OUT_W:0]    range,
  output logic              busy,
  output logic              valid,
  output logic [OUT_W-1:0]  rand_out,
  output logic              fallback,
  output logic [LFSR_W-1:0] lfsr_state
);

  localparam int               TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
  localparam logic [OUT_W:0]   RANGE_ONE = 1;

  typedef enum logic {IDLE, DRAW} state_t;

  state_t            state, state_nxt;
  logic [LFSR_W-1:0] lfsr, lfsr_nxt;
  logic [OUT_W:0]    range_q, range_nxt;
  logic [TRY_W-1:0]  tries, tries_nxt;
  logic [OUT_W-1:0]  rand_nxt;
  logic              valid_nxt;
  logic              fallback_nxt;
  logic [OUT_W:0]    cand;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] x);
    return (x >> 1) ^ (x[0] ? TAPS : '0);
  endfunction

  // A zero range would never accept; it behaves as a single-outcome roll.
  function automatic logic [OUT_W:0] clamp_range(input logic [OUT_W:0] r);
    return (r == '0) ? RANGE_ONE : r;
  endfunction

  assign cand       = {1'b0, lfsr[OUT_W-1:0]};
  assign busy       = (state == DRAW);
  assign lfsr_state = lfsr;

  always_comb begin
    if (seed_ld) lfsr_nxt = (seed == '0) ? SEED_INIT : seed;
    else         lfsr_nxt = lfsr_step(lfsr);
  end

  always_comb begin
    state_nxt    = state;
    range_nxt    = range_q;
    tries_nxt    = tries;
    rand_nxt     = rand_out;
    valid_nxt    = 1'b0;
    fallback_nxt = fallback;
    case (state)
      IDLE: begin
        if (req) begin
          range_nxt = clamp_range(range);
          tries_nxt = '0;
          state_nxt = DRAW;
        end
      end
      DRAW: begin
        if (cand < range_q) begin
          rand_nxt     = lfsr[OUT_W-1:0];
          valid_nxt    = 1'b1;
          fallback_nxt = 1'b0;
          state_nxt    = IDLE;
        end else if (tries == LAST_TRY) begin
          rand_nxt     = '0;
          valid_nxt    = 1'b1;
          fallback_nxt = 1'b1;
          state_nxt    = IDLE;
        end else begin
          tries_nxt = tries + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      lfsr     <= SEED_INIT;
      state    <= IDLE;
      range_q  <= RANGE_ONE;
      tries    <= '0;
      valid    <= 1'b0;
      rand_out <= '0;
      fallback <= 1'b0;
    end else begin
      lfsr     <= lfsr_nxt;
      state    <= state_nxt;
      range_q  <= range_nxt;
      tries    <= tries_nxt;
      valid    <= valid_nxt;
      rand_out <= rand_nxt;
      fallback <= fallback_nxt;
    end
  end

endmodule

// File: tb/tb_lfsr_rand_range.sv
// Scoreboard bench for lfsr_rand_range: a driver predicts each roll from a
// reference LFSR sequence, and an independent monitor checks every valid pulse.
`timescale 1ns/1ps
module tb_lfsr_rand_range;

  localparam int          LFSR_W    = 16;
  localparam int          OUT_W     = 3;
  localparam int          MAX_TRIES = 8;
  localparam logic [15:0] TAPS      = 16'hB400;
  localparam logic [15:0] SEED_INIT = 16'hFFFF;

  logic        Clk = 1'b0;
  logic        Reset, seed_ld, req;
  logic [15:0] seed;
  logic [3:0]  range;
  logic        busy, valid, fallback;
  logic [2:0]  rand_out;
  logic [15:0] lfsr_state;

  lfsr_rand_range #(
    .LFSR_W(LFSR_W), .TAPS(TAPS), .SEED_INIT(SEED_INIT),
    .OUT_W(OUT_W), .MAX_TRIES(MAX_TRIES)
  ) dut (
    .Clk(Clk), .Reset(Reset), .seed_ld(seed_ld), .seed(seed),
    .req(req), .range(range), .busy(busy), .valid(valid),
    .rand_out(rand_out), .fallback(fallback), .lfsr_state(lfsr_state)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0] val;
    logic       fb;
    int         vcyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] model;
  bit          period_run = 0, early_ret = 0, zero_seen = 0;
  int          pn = 0;
  bit          phase5 = 0;
  int          hist[8];

  function automatic logic [15:0] step(input logic [15:0] x);
    return {1'b0, x[15:1]} ^ (x[0] ? TAPS : 16'h0000);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // One clock: the reference register follows reset / seed load / step rules.
  task automatic cycle();
    @(posedge Clk);
    cyc++;
    if (Reset)        model = SEED_INIT;
    else if (seed_ld) model = (seed == 16'h0) ? SEED_INIT : seed;
    else              model = step(model);
    @(negedge Clk);
    chk("lfsr_vs_model", lfsr_state, model);
    if (period_run) begin
      pn++;
      if (lfsr_state == 16'h0) zero_seen = 1;
      if (pn < 65535 && lfsr_state == SEED_INIT) early_ret = 1;
      if (pn == 65535) begin
        chk("lfsr_period_return", lfsr_state, SEED_INIT);
        chk("lfsr_zero_or_early_return", {30'h0, zero_seen, early_ret}, 0);
        period_run = 0;
      end
    end
  endtask

  // Draws come from successive LFSR states; first in-range draw wins, else fallback.
  task automatic predict(input logic [3:0] rng, output int vcyc);
    exp_t        e;
    logic [15:0] x;
    int          lim;
    lim    = (rng == 0) ? 1 : int'(rng);
    x      = model;
    e.val  = 3'd0;
    e.fb   = 1'b1;
    e.vcyc = cyc + 1 + MAX_TRIES;
    for (int k = 0; k < MAX_TRIES; k++) begin
      x = step(x);
      if (int'(x[2:0]) < lim) begin
        e.val  = x[2:0];
        e.fb   = 1'b0;
        e.vcyc = cyc + 2 + k;
        break;
      end
    end
    sb.push_back(e);
    vcyc = e.vcyc;
  endtask

  task automatic roll(input logic [3:0] rng, input bit noise);
    int vcyc;
    predict(rng, vcyc);
    req = 1'b1;
    range = rng;
    cycle();
    req = 1'b0;
    range = 4'($urandom_range(0, 15));
    while (cyc < vcyc) begin
      req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      cycle();
    end
    req = 1'b0;
  endtask

  // Monitor: every valid must match the oldest prediction, on its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (valid) begin
        chk("busy_valid_overlap", {31'h0, busy}, 0);
        if (phase5) hist[rand_out]++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got valid=1 rand_out=%0d, expected no valid (cycle %0d)", rand_out, cyc);
        end else begin
          e = sb.pop_front();
          chk("rand_out", {29'h0, rand_out}, {29'h0, e.val});
          chk("fallback", {31'h0, fallback}, {31'h0, e.fb});
          chk("valid_cycle", cyc, e.vcyc);
        end
      end else if (sb.size() > 0 && sb[0].vcyc < cyc) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_valid: got no valid, expected valid at cycle %0d (now %0d)", e.vcyc, cyc);
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          c;
    logic [2:0]  snap;
    exp_t        e;
    Reset = 1'b1; seed_ld = 1'b0; seed = 16'h0; req = 1'b0; range = 4'd0;
    model = SEED_INIT;
    repeat (3) cycle();
    chk("reset_lfsr", lfsr_state, SEED_INIT);
    chk("reset_busy", {31'h0, busy}, 0);
    chk("reset_valid", {31'h0, valid}, 0);
    chk("reset_rand_out", {29'h0, rand_out}, 0);
    chk("reset_fallback", {31'h0, fallback}, 0);
    Reset = 1'b0;
    period_run = 1;
    pn = 0;
    cycle();
    chk("lfsr_first_step", lfsr_state, 16'hCBFF);

    // Full range: accepted on the first draw.
    c = cyc;
    predict(4'd8, c);
    c = cyc;
    req = 1'b1; range = 4'd8;
    cycle();
    req = 1'b0;
    snap = lfsr_state[2:0];
    cycle();
    chk("full_range_valid", {31'h0, valid}, 1);
    chk("full_range_latency", cyc - c, 2);
    chk("full_range_value", {29'h0, rand_out}, {29'h0, snap});
    chk("full_range_fallback", {31'h0, fallback}, 0);

    // range=5 population, with back-to-back and spaced rolls.
    phase5 = 1;
    for (int i = 0; i < 10000; i++) begin
      roll(4'd5, i[0]);
      repeat ($urandom_range(0, 2)) cycle();
    end
    cycle();
    phase5 = 0;
    for (int v = 0; v < 5; v++) chk("range5_value_seen", {31'h0, hist[v] > 0}, 1);
    for (int v = 5; v < 8; v++) chk("range5_value_out_of_range", hist[v], 0);
    chk("range5_roll_count", hist[0] + hist[1] + hist[2] + hist[3] + hist[4], 10000);

    // Random ranges until the LFSR has completed one full period.
    while (period_run) begin
      roll(4'($urandom_range(0, 8)), 1'b1);
      repeat ($urandom_range(0, 3)) cycle();
    end

    // Fallback: seed held so every draw sees low bits 7 against range 1.
    seed_ld = 1'b1; seed = 16'hABC7;
    cycle();
    chk("seed_load_abc7", lfsr_state, 16'hABC7);
    c = cyc;
    e.val = 3'd0; e.fb = 1'b1; e.vcyc = c + 1 + MAX_TRIES;
    sb.push_back(e);
    req = 1'b1; range = 4'd1;
    cycle();
    req = 1'b0;
    while (cyc < c + 1 + MAX_TRIES) cycle();
    chk("fallback_valid", {31'h0, valid}, 1);
    chk("fallback_flag", {31'h0, fallback}, 1);
    chk("fallback_value", {29'h0, rand_out}, 0);
    seed_ld = 1'b0;
    cycle();

    // Seed handling.
    seed_ld = 1'b1; seed = 16'h0000;
    cycle();
    chk("seed_zero_to_init", lfsr_state, SEED_INIT);
    seed = 16'h1234;
    cycle();
    chk("seed_1234", lfsr_state, 16'h1234);
    seed_ld = 1'b0;
    cycle();

    for (int i = 0; i < 20; i++) begin
      roll(4'd0, 1'b1);
      chk("range0_value", {29'h0, rand_out}, 0);
    end

    // Reset in the middle of a roll that keeps rejecting.
    seed_ld = 1'b1; seed = 16'hABC7;
    cycle();
    req = 1'b1; range = 4'd1;
    cycle();
    req = 1'b0;
    cycle();
    chk("draw_busy_before_reset", {31'h0, busy}, 1);
    Reset = 1'b1; seed_ld = 1'b0;
    cycle();
    Reset = 1'b0;
    chk("abort_busy", {31'h0, busy}, 0);
    chk("abort_valid", {31'h0, valid}, 0);
    chk("abort_lfsr", lfsr_state, SEED_INIT);
    chk("abort_rand_out", {29'h0, rand_out}, 0);
    chk("abort_fallback", {31'h0, fallback}, 0);
    repeat (MAX_TRIES + 4) cycle();

    for (int i = 0; i < 5; i++) roll(4'($urandom_range(1, 8)), 1'b0);
    repeat (MAX_TRIES + 4) cycle();
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
